// File: rtl/elevator_pkg.sv
// Shared floor/direction/door codes and call-set payload for the elevator call panel.
package elevator_pkg;

  localparam int unsigned NUM_FLOORS = 4;
  localparam int unsigned FLR_W      = $clog2(NUM_FLOORS);
  localparam int unsigned PEND_W     = 4;
  localparam int unsigned CALL_BITS  = 3 * NUM_FLOORS;

  typedef enum logic [FLR_W-1:0] {F0, F1, F2, F3} floor_t;
  typedef enum logic [1:0] {MOVE_UP = 2'b01, MOVE_DOWN = 2'b10, STOP = 2'b11} dir_t;
  typedef enum logic {CLOSE = 1'b0, OPEN = 1'b1} door_t;

  // One bit per floor for each call class; used for lamps and pulses alike.
  typedef struct packed {
    logic [NUM_FLOORS-1:0] car;
    logic [NUM_FLOORS-1:0] down;
    logic [NUM_FLOORS-1:0] up;
  } call_set_t;

  function automatic logic [PEND_W-1:0] popcount(input logic [CALL_BITS-1:0] v);
    logic [PEND_W-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < CALL_BITS; i++) n = n + PEND_W'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/elevator_call_panel_if.sv
// Call interface between the call panel (master/producer) and the elevator controller (slave).
interface elevator_call_panel_if;
  import elevator_pkg::*;

  logic [FLR_W-1:0]      current_floor;
  logic [1:0]            direction;
  logic                  door_state;
  logic                  over_weight;
  logic [NUM_FLOORS-1:0] move_up_call;
  logic [NUM_FLOORS-1:0] move_down_call;
  logic [NUM_FLOORS-1:0] req_floor;

  modport master (
    input  current_floor, direction, door_state, over_weight,
    output move_up_call, move_down_call, req_floor
  );

  modport slave (
    output current_floor, direction, door_state, over_weight,
    input  move_up_call, move_down_call, req_floor
  );

endinterface

// File: rtl/call_debounce.sv
// One button: 2-flop synchroniser, consecutive-sample debounce counter, registered press event.
module call_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             sync2;
  logic             accepted;
  logic [CNT_W-1:0] cnt;
  logic             flip_c;

  // Last differing sample of a full run flips the accepted level.
  assign flip_c = (sync2 != accepted) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      accepted <= 1'b0;
      cnt      <= '0;
      press    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= flip_c && !accepted;
      if (sync2 == accepted) begin
        cnt <= '0;
      end else if (flip_c) begin
        accepted <= ~accepted;
        cnt      <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/elevator_call_panel.sv
// Call-entry front end: debounced buttons, latched lamps, one-cycle call pulses, service clearing.
// Optional CALL_CANCEL_EN: re-pressing a lit car button cancels it and pulses car_cancel.
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] btn_up,
  input  logic [NUM_FLOORS-1:0] btn_down,
  input  logic [NUM_FLOORS-1:0] btn_car,
  elevator_call_panel_if.master call_bus,
  output logic [NUM_FLOORS-1:0] lamp_up,
  output logic [NUM_FLOORS-1:0] lamp_down,
  output logic [NUM_FLOORS-1:0] lamp_car,
  output logic [PEND_W-1:0]     pending_count
`ifdef CALL_CANCEL_EN
  ,
  output logic [NUM_FLOORS-1:0] car_cancel
`endif
);

  // No up call at the top floor, no down call at ground.
  localparam logic [NUM_FLOORS-1:0] UP_OK = ~(NUM_FLOORS'(1) << (NUM_FLOORS - 1));
  localparam logic [NUM_FLOORS-1:0] DN_OK = ~NUM_FLOORS'(1);

  logic [NUM_FLOORS-1:0] press_up;
  logic [NUM_FLOORS-1:0] press_down;
  logic [NUM_FLOORS-1:0] press_car;

  call_set_t             lamp_q;
  call_set_t             lamp_n;
  call_set_t             pulse_q;
  call_set_t             pulse_n;
  logic [PEND_W-1:0]     pend_q;
  logic [PEND_W-1:0]     pend_n;
  dir_t                  last_dir;
  logic                  door_q;
  logic                  service_c;
  logic [NUM_FLOORS-1:0] at_f;
`ifdef CALL_CANCEL_EN
  logic [NUM_FLOORS-1:0] cancel_q;
  logic [NUM_FLOORS-1:0] cancel_n;
`endif

  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_btn
    call_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk(clk), .rst(rst), .raw(btn_up[f]), .press(press_up[f]));
    call_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clk(clk), .rst(rst), .raw(btn_down[f]), .press(press_down[f]));
    call_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_car (
      .clk(clk), .rst(rst), .raw(btn_car[f]), .press(press_car[f]));
  end

  // Next lamps/pulses; a service clear on a lamp beats a press on it in the same cycle.
  always_comb begin
    lamp_n  = lamp_q;
    pulse_n = '0;
    at_f    = '0;
`ifdef CALL_CANCEL_EN
    cancel_n = '0;
`endif
    service_c = (call_bus.door_state == OPEN) && !door_q && !call_bus.over_weight;
    for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
      at_f[i] = (call_bus.current_floor == FLR_W'(i));

      if (service_c && at_f[i] && (last_dir == MOVE_UP || last_dir == STOP || i == 0)) begin
        lamp_n.up[i] = 1'b0;
      end else if (press_up[i] && !lamp_q.up[i]) begin
        lamp_n.up[i]  = 1'b1;
        pulse_n.up[i] = 1'b1;
      end

      if (service_c && at_f[i] &&
          (last_dir == MOVE_DOWN || last_dir == STOP || i == NUM_FLOORS - 1)) begin
        lamp_n.down[i] = 1'b0;
      end else if (press_down[i] && !lamp_q.down[i]) begin
        lamp_n.down[i]  = 1'b1;
        pulse_n.down[i] = 1'b1;
      end

      // Car presses for the floor whose door is open are dropped.
      if (service_c && at_f[i]) begin
        lamp_n.car[i] = 1'b0;
      end else if (press_car[i] && !((call_bus.door_state == OPEN) && at_f[i])) begin
        if (!lamp_q.car[i]) begin
          lamp_n.car[i]  = 1'b1;
          pulse_n.car[i] = 1'b1;
        end
`ifdef CALL_CANCEL_EN
        else begin
          lamp_n.car[i] = 1'b0;
          cancel_n[i]   = 1'b1;
        end
`endif
      end
    end
    lamp_n.up    = lamp_n.up & UP_OK;
    lamp_n.down  = lamp_n.down & DN_OK;
    pulse_n.up   = pulse_n.up & UP_OK;
    pulse_n.down = pulse_n.down & DN_OK;
    pend_n       = popcount(lamp_n);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lamp_q   <= '0;
      pulse_q  <= '0;
      pend_q   <= '0;
      last_dir <= STOP;
      door_q   <= 1'b0;
`ifdef CALL_CANCEL_EN
      cancel_q <= '0;
`endif
    end else begin
      lamp_q  <= lamp_n;
      pulse_q <= pulse_n;
      pend_q  <= pend_n;
      door_q  <= call_bus.door_state;
      if (call_bus.direction == MOVE_UP || call_bus.direction == MOVE_DOWN)
        last_dir <= dir_t'(call_bus.direction);
`ifdef CALL_CANCEL_EN
      cancel_q <= cancel_n;
`endif
    end
  end

  assign call_bus.move_up_call   = pulse_q.up;
  assign call_bus.move_down_call = pulse_q.down;
  assign call_bus.req_floor      = pulse_q.car;
  assign lamp_up                 = lamp_q.up;
  assign lamp_down               = lamp_q.down;
  assign lamp_car                = lamp_q.car;
  assign pending_count           = pend_q;
`ifdef CALL_CANCEL_EN
  assign car_cancel              = cancel_q;
`endif

endmodule

// File: tb/tb_elevator_call_panel.sv
// Self-checking bench for elevator_call_panel (DEBOUNCE_CYCLES=4), directed scenarios plus random traffic.
module tb_elevator_call_panel;
  import elevator_pkg::*;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_up = '0, btn_down = '0, btn_car = '0;
  logic [3:0] lamp_up, lamp_down, lamp_car, pending_count;
`ifdef CALL_CANCEL_EN
  logic [3:0] car_cancel;
`endif
  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  elevator_call_panel_if bus ();

  elevator_call_panel #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_car(btn_car),
    .call_bus(bus), .lamp_up(lamp_up), .lamp_down(lamp_down), .lamp_car(lamp_car),
    .pending_count(pending_count)
`ifdef CALL_CANCEL_EN
    , .car_cancel(car_cancel)
`endif
  );

  // Reference model: bit g*4+f, g = 0 up / 1 down / 2 car.
  logic [11:0] m_acc, m_lamp, m_pulse;
  int          m_run[12];
  logic [11:0] m_pipe[3];
  logic [3:0]  m_cancel;
  logic [1:0]  m_dir;
  logic        m_door_q;

  function automatic logic [31:0] dut_vec();
    logic [3:0] cc;
    cc = 4'b0;
`ifdef CALL_CANCEL_EN
    cc = car_cancel;
`endif
    return {cc, pending_count, lamp_car, lamp_down, lamp_up,
            bus.req_floor, bus.move_down_call, bus.move_up_call};
  endfunction

  function automatic logic [31:0] m_vec();
    return {m_cancel, 4'($countones(m_lamp)), m_lamp, m_pulse};
  endfunction

  task automatic model_reset();
    m_acc = '0; m_lamp = '0; m_pulse = '0; m_cancel = '0; m_dir = 2'b11; m_door_q = 1'b0;
    for (int b = 0; b < 12; b++) m_run[b] = 0;
    for (int k = 0; k < 3; k++) m_pipe[k] = '0;
  endtask

  // A press accepted from raw samples at edge k shows up on the outputs at edge k+3.
  task automatic model_step();
    logic [11:0] raw, eff, ev;
    logic svc, at_svc, at_floor;
    raw = {btn_car, btn_down, btn_up};
    eff = m_pipe[2];
    m_pipe[2] = m_pipe[1];
    m_pipe[1] = m_pipe[0];
    ev = '0;
    for (int b = 0; b < 12; b++) begin
      if (raw[b] != m_acc[b]) begin
        m_run[b]++;
        if (m_run[b] == N) begin
          m_acc[b] = ~m_acc[b];
          m_run[b] = 0;
          ev[b] = m_acc[b];
        end
      end else m_run[b] = 0;
    end
    m_pipe[0] = ev;
    svc = bus.door_state && !m_door_q && !bus.over_weight;
    m_pulse = '0;
    m_cancel = '0;
    for (int f = 0; f < 4; f++) begin
      at_floor = (bus.current_floor == 2'(f));
      at_svc = svc && at_floor;
      if (f != 3) begin
        if (at_svc && (m_dir != 2'b10 || f == 0)) m_lamp[f] = 1'b0;
        else if (eff[f] && !m_lamp[f]) begin m_lamp[f] = 1'b1; m_pulse[f] = 1'b1; end
      end
      if (f != 0) begin
        if (at_svc && (m_dir != 2'b01 || f == 3)) m_lamp[4+f] = 1'b0;
        else if (eff[4+f] && !m_lamp[4+f]) begin m_lamp[4+f] = 1'b1; m_pulse[4+f] = 1'b1; end
      end
      if (at_svc) m_lamp[8+f] = 1'b0;
      else if (eff[8+f] && !(bus.door_state && at_floor)) begin
        if (!m_lamp[8+f]) begin m_lamp[8+f] = 1'b1; m_pulse[8+f] = 1'b1; end
`ifdef CALL_CANCEL_EN
        else begin m_lamp[8+f] = 1'b0; m_cancel[f] = 1'b1; end
`endif
      end
    end
    if (bus.direction == 2'b01 || bus.direction == 2'b10) m_dir = bus.direction;
    m_door_q = bus.door_state;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
  endtask

  task automatic do_reset();
    #2 rst = 1'b0;
    tick();
    #2 rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 model_reset();
    n_chk++;
    if (dut_vec() !== 32'h0) $display("FAIL reset_now got=%h exp=%h", dut_vec(), 32'h0);
    else n_pass++;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_chk++;
      if (dut_vec() !== m_vec()) $display("FAIL reset_hold c=%0d got=%h exp=%h", c, dut_vec(), m_vec());
      else n_pass++;
    end
    #2 rst = 1'b1;
  endtask

  task automatic test_car_press();
    btn_car[2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_chk++;
      if (dut_vec() !== m_vec()) $display("FAIL car_model c=%0d got=%h exp=%h", c, dut_vec(), m_vec());
      else n_pass++;
      n_chk++;
      if (bus.req_floor[2] !== (c == 6)) $display("FAIL car_pulse c=%0d got=%b exp=%b", c, bus.req_floor[2], (c == 6));
      else n_pass++;
    end
    btn_car[2] = 1'b0;
    n_chk++;
    if ({lamp_car, pending_count} !== {4'b0100, 4'd1})
      $display("FAIL car_lamp got=%h exp=%h", {lamp_car, pending_count}, {4'b0100, 4'd1});
    else n_pass++;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_chk++;
      if (dut_vec() !== m_vec()) $display("FAIL car_release c=%0d got=%h exp=%h", c, dut_vec(), m_vec());
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    bit pat[11] = '{1, 1, 1, 0, 1, 1, 1, 1, 1, 1, 1};
    int pulses = 0;
    int at = -1;
    for (int c = 0; c < 19; c++) begin
      btn_up[1] = (c < 11) ? pat[c] : 1'b0;
      tick();
      if (bus.move_up_call[1]) begin pulses++; at = c; end
      n_chk++;
      if (dut_vec() !== m_vec()) $display("FAIL bounce_model c=%0d got=%h exp=%h", c, dut_vec(), m_vec());
      else n_pass++;
    end
    n_chk++;
    if (pulses !== 1 || at !== 10) $display("FAIL bounce_pulse got=%0d@%0d exp=1@10", pulses, at);
    else n_pass++;
  endtask

  task automatic test_repeat_press();
    int reqs = 0;
    int cancels = 0;
    btn_car[2] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (c == 8) btn_car[2] = 1'b0;
      tick();
      if (bus.req_floor[2]) reqs++;
`ifdef CALL_CANCEL_EN
      if (car_cancel[2]) cancels++;
`endif
      n_chk++;
      if (dut_vec() !== m_vec()) $display("FAIL repeat_model c=%0d got=%h exp=%h", c, dut_vec(), m_vec());
      else n_pass++;
    end
`ifdef CALL_CANCEL_EN
    n_chk++;
    if ({reqs, cancels, 31'd0, lamp_car[2]} !== {32'd0, 32'd1, 32'd0})
      $display("FAIL repeat_cancel got=%0d/%0d/%b exp=0/1/0", reqs, cancels, lamp_car[2]);
    else n_pass++;
`else
    n_chk++;
    if ({reqs, cancels, 31'd0, lamp_car[2]} !== {32'd0, 32'd0, 32'd1})
      $display("FAIL repeat_ignore got=%0d/%0d/%b exp=0/0/1", reqs, cancels, lamp_car[2]);
    else n_pass++;
`endif
  endtask

  task automatic test_service();
    for (int ow = 0; ow < 2; ow++) begin
      do_reset();
      bus.current_floor = 2'd1; bus.door_state = 1'b0; bus.over_weight = 1'b0; bus.direction = 2'b11;
      btn_up[1] = 1'b1; btn_down[1] = 1'b1; btn_car[1] = 1'b1;
      for (int c = 0; c < 15; c++) begin
        if (c == 7) begin btn_up[1] = 1'b0; btn_down[1] = 1'b0; btn_car[1] = 1'b0; end
        if (c == 10) bus.direction = 2'b01;
        if (c == 12) bus.direction = 2'b11;
        tick();
        n_chk++;
        if (dut_vec() !== m_vec()) $display("FAIL svc_setup ow=%0d c=%0d got=%h exp=%h", ow, c, dut_vec(), m_vec());
        else n_pass++;
      end
      n_chk++;
      if (pending_count !== 4'd3) $display("FAIL svc_before ow=%0d got=%0d exp=3", ow, pending_count);
      else n_pass++;
      bus.over_weight = 1'(ow);
      bus.door_state = 1'b1;
      tick();
      n_chk++;
      if (dut_vec() !== m_vec()) $display("FAIL svc_model ow=%0d got=%h exp=%h", ow, dut_vec(), m_vec());
      else n_pass++;
      n_chk++;
      if (ow == 0 && {lamp_up[1], lamp_down[1], lamp_car[1], pending_count} !== {3'b010, 4'd1})
        $display("FAIL svc_clear got=%b%b%b cnt=%0d exp=010 cnt=1", lamp_up[1], lamp_down[1], lamp_car[1], pending_count);
      else if (ow == 1 && {lamp_up[1], lamp_down[1], lamp_car[1], pending_count} !== {3'b111, 4'd3})
        $display("FAIL svc_overweight got=%b%b%b cnt=%0d exp=111 cnt=3", lamp_up[1], lamp_down[1], lamp_car[1], pending_count);
      else n_pass++;
      bus.door_state = 1'b0;
      bus.over_weight = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    bus.current_floor = 2'd0;
    btn_down[2] = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    #2 rst = 1'b0;
    #1 model_reset();
    n_chk++;
    if (dut_vec() !== 32'h0) $display("FAIL midrst_now got=%h exp=%h", dut_vec(), 32'h0);
    else n_pass++;
    tick();
    tick();
    #2 rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_chk++;
      if (bus.move_down_call[2] !== (c == 6))
        $display("FAIL midrst_pulse c=%0d got=%b exp=%b", c, bus.move_down_call[2], (c == 6));
      else n_pass++;
      n_chk++;
      if (dut_vec() !== m_vec()) $display("FAIL midrst_model c=%0d got=%h exp=%h", c, dut_vec(), m_vec());
      else n_pass++;
    end
    btn_down[2] = 1'b0;
  endtask

  task automatic test_random();
    int hold[12];
    logic [11:0] lvl = '0;
    for (int b = 0; b < 12; b++) hold[b] = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int b = 0; b < 12; b++) begin
        if (hold[b] == 0) begin
          lvl[b] = ($urandom_range(0, 2) == 0);
          hold[b] = $urandom_range(1, 9);
        end
        hold[b]--;
      end
      {btn_car, btn_down, btn_up} = lvl;
      if ($urandom_range(0, 7) == 0) bus.current_floor = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) bus.direction = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) bus.door_state = ~bus.door_state;
      bus.over_weight = ($urandom_range(0, 4) == 0);
      tick();
      n_chk++;
      if (dut_vec() !== m_vec()) $display("FAIL random c=%0d got=%h exp=%h", c, dut_vec(), m_vec());
      else n_pass++;
    end
  endtask

  initial begin
    bus.current_floor = 2'd0;
    bus.direction     = 2'b11;
    bus.door_state    = 1'b0;
    bus.over_weight   = 1'b0;
    model_reset();
    test_reset();
    test_car_press();
    test_bounce();
    test_repeat_press();
    test_service();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
